// File: rtl/ctrl_unit_if.sv
// Instruction-fetch bus between ctrl_unit and instruction memory.
// Request/valid handshake: the master holds addr while req is high.
`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT    8
`define ALU_MODE_ADD      0
`define ALU_MODE_SHIFT    1
`define ALU_MODE_NOT      2
`define ALU_MODE_AND      3
`define ALU_MODE_OR       4
`define ALU_MODE_XOR      5
`define ALU_MODE_BYPASS_A 6
`define ALU_MODE_BYPASS_B 7
`endif
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 2
`define ALU_FLAG_EQ    0
`define ALU_FLAG_GT    1
`endif

interface ctrl_unit_if #(
    parameter int BIT_COUNT = 8
);
    logic [BIT_COUNT-1:0] imem_addr;
    logic                 imem_req;
    logic                 imem_valid;
    logic [7:0]           imem_data;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/ctrl_unit.sv
// Multi-cycle FETCH/DECODE/EXEC control unit for the 8-bit accumulator core.
// Owns the PC, decodes instructions to ALU/regfile controls and resolves branches.
`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT    8
`define ALU_MODE_ADD      0
`define ALU_MODE_SHIFT    1
`define ALU_MODE_NOT      2
`define ALU_MODE_AND      3
`define ALU_MODE_OR       4
`define ALU_MODE_XOR      5
`define ALU_MODE_BYPASS_A 6
`define ALU_MODE_BYPASS_B 7
`endif
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 2
`define ALU_FLAG_EQ    0
`define ALU_FLAG_GT    1
`endif

module ctrl_unit #(
    parameter int BIT_COUNT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ctrl_unit_if.master                imem,
    input  logic [`ALU_FLAG_COUNT-1:0] alu_flags,
    output logic [`ALU_MODE_COUNT-1:0] alu_mode,
    output logic                       a_sel,
    output logic                       b_sel,
    output logic [3:0]                 imm,
    output logic [2:0]                 rs_addr,
    output logic [2:0]                 rd_addr,
    output logic                       rd_we,
    output logic                       acc_we,
    output logic [BIT_COUNT-1:0]       pc,
    output logic                       halted
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    state_t                     state_reg, state_next;
    logic [7:0]                 ir_reg, ir_next;
    logic [BIT_COUNT-1:0]       pc_reg, pc_next;
    logic [`ALU_FLAG_COUNT-1:0] flag_reg, flag_next;
    logic [`ALU_MODE_COUNT-1:0] mode_reg, mode_next;
    logic                       a_sel_reg, a_sel_next;
    logic                       b_sel_reg, b_sel_next;
    logic [3:0]                 imm_reg, imm_next;
    logic [2:0]                 rs_reg, rs_next;
    logic [2:0]                 rd_reg, rd_next;
    logic                       rd_we_reg, rd_we_next;
    logic                       acc_we_reg, acc_we_next;
    logic                       req_reg, req_next;
    logic                       halted_reg, halted_next;

    // One decoder serves both the fetch edge (fresh data) and the decode edge (latched ir).
    logic [7:0]                 dec_src;
    logic [`ALU_MODE_COUNT-1:0] dec_mode;
    logic                       dec_a_sel, dec_b_sel, dec_acc_we, dec_rd_we;
    logic                       taken;
    logic [BIT_COUNT-1:0]       branch_off;

    assign dec_src    = (state_reg == FETCH) ? imem.imem_data : ir_reg;
    assign branch_off = {{(BIT_COUNT-4){ir_reg[3]}}, ir_reg[3:0]};
    assign taken      = ((ir_reg[7:4] == 4'hC) && flag_reg[`ALU_FLAG_EQ]) ||
                        ((ir_reg[7:4] == 4'hD) && flag_reg[`ALU_FLAG_GT]) ||
                         (ir_reg[7:4] == 4'hE);

    always_comb begin
        dec_mode   = '0;
        dec_a_sel  = 1'b0;
        dec_b_sel  = 1'b0;
        dec_acc_we = 1'b0;
        dec_rd_we  = 1'b0;
        case (dec_src[7:4])
            4'h1: begin dec_mode[`ALU_MODE_ADD]   = 1'b1; dec_acc_we = 1'b1; end
            4'h2: begin dec_mode[`ALU_MODE_ADD]   = 1'b1; dec_b_sel = 1'b1; dec_acc_we = 1'b1; end
            4'h3: begin dec_mode[`ALU_MODE_SHIFT] = 1'b1; dec_acc_we = 1'b1; end
            4'h4: begin dec_mode[`ALU_MODE_SHIFT] = 1'b1; dec_b_sel = 1'b1; dec_acc_we = 1'b1; end
            4'h5: begin dec_mode[`ALU_MODE_NOT]   = 1'b1; dec_acc_we = 1'b1; end
            4'h6: begin dec_mode[`ALU_MODE_AND]   = 1'b1; dec_acc_we = 1'b1; end
            4'h7: begin dec_mode[`ALU_MODE_OR]    = 1'b1; dec_acc_we = 1'b1; end
            4'h8: begin dec_mode[`ALU_MODE_XOR]   = 1'b1; dec_acc_we = 1'b1; end
            4'h9: begin
                if (dec_src[2:0] == 3'd7) dec_mode[`ALU_MODE_BYPASS_A] = 1'b1;
                else                      dec_mode[`ALU_MODE_BYPASS_B] = 1'b1;
                dec_acc_we = 1'b1;
            end
            4'hA: begin
                dec_mode[`ALU_MODE_BYPASS_A] = 1'b1;
                dec_rd_we = (dec_src[2:0] != 3'd7);
            end
            // Branches present PC+imm on the ALU selects; the target itself is computed here.
            4'hC, 4'hD, 4'hE: begin dec_a_sel = 1'b1; dec_b_sel = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        ir_next     = ir_reg;
        pc_next     = pc_reg;
        flag_next   = flag_reg;
        mode_next   = mode_reg;
        a_sel_next  = a_sel_reg;
        b_sel_next  = b_sel_reg;
        imm_next    = imm_reg;
        rs_next     = rs_reg;
        rd_next     = rd_reg;
        rd_we_next  = 1'b0;
        acc_we_next = 1'b0;
        case (state_reg)
            FETCH: begin
                if (req_reg && imem.imem_valid) begin
                    ir_next    = imem.imem_data;
                    mode_next  = dec_mode;
                    a_sel_next = dec_a_sel;
                    b_sel_next = dec_b_sel;
                    imm_next   = imem.imem_data[3:0];
                    rs_next    = imem.imem_data[2:0];
                    rd_next    = imem.imem_data[2:0];
                    state_next = DECODE;
                end
            end
            DECODE: begin
                acc_we_next = dec_acc_we;
                rd_we_next  = dec_rd_we;
                state_next  = EXEC;
            end
            EXEC: begin
                if (ir_reg[7:4] == 4'hB) flag_next = alu_flags;
                pc_next    = taken ? pc_reg + branch_off : pc_reg + BIT_COUNT'(1);
                mode_next  = '0;
                state_next = (ir_reg[7:4] == 4'hF) ? HALT : FETCH;
            end
            HALT: begin
                mode_next = '0;
            end
            default: state_next = FETCH;
        endcase
        req_next    = (state_next == FETCH);
        halted_next = (state_next == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FETCH;
            ir_reg     <= '0;
            pc_reg     <= '0;
            flag_reg   <= '0;
            mode_reg   <= '0;
            a_sel_reg  <= 1'b0;
            b_sel_reg  <= 1'b0;
            imm_reg    <= '0;
            rs_reg     <= '0;
            rd_reg     <= '0;
            rd_we_reg  <= 1'b0;
            acc_we_reg <= 1'b0;
            req_reg    <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ir_reg     <= ir_next;
            pc_reg     <= pc_next;
            flag_reg   <= flag_next;
            mode_reg   <= mode_next;
            a_sel_reg  <= a_sel_next;
            b_sel_reg  <= b_sel_next;
            imm_reg    <= imm_next;
            rs_reg     <= rs_next;
            rd_reg     <= rd_next;
            rd_we_reg  <= rd_we_next;
            acc_we_reg <= acc_we_next;
            req_reg    <= req_next;
            halted_reg <= halted_next;
        end
    end

    assign imem.imem_addr = pc_reg;
    assign imem.imem_req  = req_reg;
    assign alu_mode       = mode_reg;
    assign a_sel          = a_sel_reg;
    assign b_sel          = b_sel_reg;
    assign imm            = imm_reg;
    assign rs_addr        = rs_reg;
    assign rd_addr        = rd_reg;
    assign rd_we          = rd_we_reg;
    assign acc_we         = acc_we_reg;
    assign pc             = pc_reg;
    assign halted         = halted_reg;
endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: small instruction ROM model plus hand-computed expectations.
// Mode bit order: ADD=0 SHIFT=1 NOT=2 AND=3 OR=4 XOR=5 BYPASS_A=6 BYPASS_B=7.
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 2
`define ALU_FLAG_EQ    0
`define ALU_FLAG_GT    1
`endif

module tb_ctrl_unit;
    logic                       clk;
    logic                       rst_n;
    logic [`ALU_FLAG_COUNT-1:0] alu_flags;
    logic [7:0]                 alu_mode;
    logic                       a_sel, b_sel;
    logic [3:0]                 imm;
    logic [2:0]                 rs_addr, rd_addr;
    logic                       rd_we, acc_we;
    logic [7:0]                 pc;
    logic                       halted;
    logic                       valid_en;
    logic [7:0]                 mem [256];
    int                         checks;
    int                         errors;

    ctrl_unit_if #(.BIT_COUNT(8)) bus ();

    assign bus.imem_data  = mem[bus.imem_addr];
    assign bus.imem_valid = valid_en;

    ctrl_unit #(.BIT_COUNT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (bus),
        .alu_flags (alu_flags),
        .alu_mode  (alu_mode),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .imm       (imm),
        .rs_addr   (rs_addr),
        .rd_addr   (rd_addr),
        .rd_we     (rd_we),
        .acc_we    (acc_we),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Called just after a posedge; the next posedge is cycle 1.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sweep(input logic [7:0] ins, input logic [7:0] mode, input logic aw, input logic rw);
        clear_mem();
        mem[0] = ins;
        valid_en = 1'b1;
        do_reset();
        step(2);
        chk($sformatf("sweep_mode_%02h", ins), 32'(alu_mode), 32'(mode));
        step(1);
        chk($sformatf("sweep_acc_we_%02h", ins), 32'(acc_we), 32'(aw));
        chk($sformatf("sweep_rd_we_%02h", ins), 32'(rd_we), 32'(rw));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        valid_en  = 1'b1;
        alu_flags = '0;
        clear_mem();
        mem[0] = 8'h23;
        mem[1] = 8'hA1;
        mem[2] = 8'hF0;

        // Reset values
        #3;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_mode", 32'(alu_mode), 32'h0);
        chk("rst_sels", 32'({a_sel, b_sel}), 32'h0);
        chk("rst_imm", 32'(imm), 32'h0);
        chk("rst_addrs", 32'({rs_addr, rd_addr}), 32'h0);
        chk("rst_we", 32'({rd_we, acc_we}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI 3 / ST 1 / HALT
        step(1);
        chk("p1_c1_req", 32'(bus.imem_req), 32'h1);
        chk("p1_c1_addr", 32'(bus.imem_addr), 32'h0);
        step(1);
        chk("p1_c2_req", 32'(bus.imem_req), 32'h0);
        chk("p1_c2_mode", 32'(alu_mode), 32'h01);
        chk("p1_c2_bsel", 32'(b_sel), 32'h1);
        chk("p1_c2_imm", 32'(imm), 32'h3);
        chk("p1_c2_acc_we", 32'(acc_we), 32'h0);
        step(1);
        chk("p1_c3_acc_we", 32'(acc_we), 32'h1);
        chk("p1_c3_mode", 32'(alu_mode), 32'h01);
        chk("p1_c3_halted", 32'(halted), 32'h0);
        step(1);
        chk("p1_c4_acc_we", 32'(acc_we), 32'h0);
        chk("p1_c4_pc", 32'(pc), 32'h1);
        chk("p1_c4_req", 32'(bus.imem_req), 32'h1);
        step(1);
        chk("p1_c5_mode", 32'(alu_mode), 32'h40);
        chk("p1_c5_rd_we", 32'(rd_we), 32'h0);
        step(1);
        chk("p1_c6_rd_we", 32'(rd_we), 32'h1);
        chk("p1_c6_rd_addr", 32'(rd_addr), 32'h1);
        step(1);
        chk("p1_c7_rd_we", 32'(rd_we), 32'h0);
        chk("p1_c7_pc", 32'(pc), 32'h2);
        step(3);
        chk("p1_c10_halted", 32'(halted), 32'h1);
        chk("p1_c10_req", 32'(bus.imem_req), 32'h0);
        step(3);
        chk("p1_c13_halted", 32'(halted), 32'h1);
        chk("p1_c13_req", 32'(bus.imem_req), 32'h0);

        // Fetch stall: valid low for cycles 1..4
        clear_mem();
        mem[0] = 8'h25;
        valid_en = 1'b0;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            step(1);
            chk($sformatf("stall_c%0d_req", c), 32'(bus.imem_req), 32'h1);
            chk($sformatf("stall_c%0d_addr", c), 32'(bus.imem_addr), 32'h0);
        end
        step(1);
        chk("stall_c5_req", 32'(bus.imem_req), 32'h1);
        chk("stall_c5_mode", 32'(alu_mode), 32'h0);
        valid_en = 1'b1;
        step(1);
        chk("stall_c6_req", 32'(bus.imem_req), 32'h0);
        chk("stall_c6_mode", 32'(alu_mode), 32'h01);
        chk("stall_c6_addr", 32'(bus.imem_addr), 32'h0);

        // CMP r2 at 4, BEQ -2 at 5, EQ set -> 3
        clear_mem();
        mem[4] = 8'hB2;
        mem[5] = 8'hCE;
        alu_flags = 2'b01;
        do_reset();
        step(13);
        chk("beq_t_cmp_pc", 32'(pc), 32'h4);
        step(1);
        chk("beq_t_cmp_rs", 32'(rs_addr), 32'h2);
        chk("beq_t_cmp_mode", 32'(alu_mode), 32'h0);
        step(2);
        chk("beq_t_pc", 32'(pc), 32'h5);
        step(3);
        chk("beq_t_target", 32'(bus.imem_addr), 32'h3);
        chk("beq_t_req", 32'(bus.imem_req), 32'h1);

        // Same with EQ clear -> 6
        alu_flags = 2'b00;
        do_reset();
        step(19);
        chk("beq_nt_target", 32'(bus.imem_addr), 32'h6);

        // 01 + (-8) -> F9, JMP +7 at FC -> 03
        clear_mem();
        mem[1]    = 8'hE8;
        mem[8'hFC] = 8'hE7;
        do_reset();
        step(4);
        chk("wrap_c4_pc", 32'(pc), 32'h01);
        step(3);
        chk("wrap_c7_pc", 32'(pc), 32'hF9);
        step(9);
        chk("wrap_c16_pc", 32'(pc), 32'hFC);
        step(3);
        chk("wrap_c19_pc", 32'(pc), 32'h03);
        step(3);
        chk("wrap_c22_pc", 32'(pc), 32'h04);

        // JMP -1 at 0 -> FF, NOP at FF -> 00
        clear_mem();
        mem[0] = 8'hEF;
        do_reset();
        step(4);
        chk("wrapff_c4_pc", 32'(pc), 32'hFF);
        step(3);
        chk("wrapff_c7_pc", 32'(pc), 32'h00);

        // Mode decode sweep
        alu_flags = 2'b00;
        sweep(8'h01, 8'h00, 1'b0, 1'b0);
        sweep(8'h11, 8'h01, 1'b1, 1'b0);
        sweep(8'h23, 8'h01, 1'b1, 1'b0);
        sweep(8'h31, 8'h02, 1'b1, 1'b0);
        sweep(8'h44, 8'h02, 1'b1, 1'b0);
        sweep(8'h50, 8'h04, 1'b1, 1'b0);
        sweep(8'h61, 8'h08, 1'b1, 1'b0);
        sweep(8'h71, 8'h10, 1'b1, 1'b0);
        sweep(8'h81, 8'h20, 1'b1, 1'b0);
        sweep(8'h92, 8'h80, 1'b1, 1'b0);
        sweep(8'h97, 8'h40, 1'b1, 1'b0);
        sweep(8'hA3, 8'h40, 1'b0, 1'b1);
        sweep(8'hA7, 8'h40, 1'b0, 1'b0);
        sweep(8'hB2, 8'h00, 1'b0, 1'b0);
        sweep(8'hC1, 8'h00, 1'b0, 1'b0);
        sweep(8'hD1, 8'h00, 1'b0, 1'b0);
        sweep(8'hE1, 8'h00, 1'b0, 1'b0);
        sweep(8'hF0, 8'h00, 1'b0, 1'b0);

        // Reset pulsed during EXEC of ADD r1 at pc=1
        clear_mem();
        mem[1] = 8'h11;
        do_reset();
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_acc_we", 32'(acc_we), 32'h0);
        chk("mid_pc", 32'(pc), 32'h0);
        chk("mid_req", 32'(bus.imem_req), 32'h0);
        chk("mid_mode", 32'(alu_mode), 32'h0);
        chk("mid_rs", 32'(rs_addr), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_hold_acc_we", 32'(acc_we), 32'h0);
        chk("mid_hold_pc", 32'(pc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("mid_restart_req", 32'(bus.imem_req), 32'h1);
        chk("mid_restart_addr", 32'(bus.imem_addr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
